// File: rtl/seq_chunk_adder.sv
// Sequential add/subtract unit: adds WIDTH-bit operands CHUNK bits per clock with a carry register.
// Define SEQ_CHUNK_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_sum;
    logic             last;
    logic             ovf_next;

    always_comb begin
        base      = 32'(idx_q) * CHUNK;
        a_sl      = a_q[base +: CHUNK];
        b_sl      = b_q[base +: CHUNK];
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry_q);
        last      = (idx_q == IW'(N - 1));
        // Carry into the MSB is recovered as a ^ b ^ s at that bit position.
        ovf_next  = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1] ^ slice_sum[CHUNK];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    sum[base +: CHUNK] <= slice_sum[CHUNK-1:0];
                    carry_q            <= slice_sum[CHUNK];
                    idx_q              <= idx_q + 1'b1;
                    if (last) begin
                        idx_q <= '0;
                        cout  <= slice_sum[CHUNK];
                        done  <= 1'b1;
                        state <= StDone;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                        ovf   <= ovf_next;
`endif
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef SEQ_CHUNK_ADDER_OVF_EN
    logic unused_ovf;
    assign unused_ovf = ovf_next;
`endif

endmodule
